// File: rtl/fetch_unit.sv
// Instruction-fetch stage: req/ack handshake with instruction memory, IR latch, PCWr pulse,
// flush/drain handling and misaligned-PC flag. Define FETCH_PERF_EN to enable fetch/stall counters.
module fetch_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] PC,
  input  logic          fetch_start,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] IR,
  output logic          ir_valid,
  output logic          PCWr,
  output logic          busy,
  output logic          misalign,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic   start_ok_s;
  logic   start_bad_s;
  logic   req_s;
  logic   valid_s;
  logic   busy_s;

  // Qualify a fetch request seen in IDLE (aligned vs misaligned)
  always_comb begin
    start_ok_s  = 1'b0;
    start_bad_s = 1'b0;
    if ((state_r == IDLE) && fetch_start && !flush) begin
      if (PC[1:0] == 2'b00) begin
        start_ok_s = 1'b1;
      end else begin
        start_bad_s = 1'b1;
      end
    end else begin
      start_ok_s  = 1'b0;
      start_bad_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a raised request is only ever retired by an ack
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_next_s = REQ;
        else            state_next_s = IDLE;
      end
      REQ: begin
        if (imem_ack) begin
          if (flush) state_next_s = IDLE;
          else       state_next_s = DONE;
        end else if (flush) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = REQ;
        end
      end
      DRAIN: begin
        if (imem_ack) state_next_s = IDLE;
        else          state_next_s = DRAIN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode, purely from the state register
  always_comb begin
    req_s   = 1'b0;
    valid_s = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      REQ, DRAIN: begin
        req_s  = 1'b1;
        busy_s = 1'b1;
      end
      DONE: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign imem_req = req_s;
  assign ir_valid = valid_s;
  assign PCWr     = valid_s;
  assign busy     = busy_s;

  // Fetch address, instruction register and misalign flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_addr <= {AW{1'b0}};
      IR        <= {DW{1'b0}};
      misalign  <= 1'b0;
    end else begin
      if (start_ok_s) begin
        imem_addr <= PC;
      end
      if ((state_r == REQ) && imem_ack && !flush) begin
        IR <= imem_rdata;
      end
      misalign <= start_bad_s;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  // Performance counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (state_r == DONE) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
      if (((state_r == REQ) || (state_r == DRAIN)) && !imem_ack) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_r;
  assign stall_cnt = stall_cnt_r;
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule
